// File: rtl/instr_reg_scheduler_pkg.sv
// Shared types for the instruction register and its front-end scheduler.
package instr_reg_scheduler_pkg;

  localparam int IR_NUM_REQ = 2;
  localparam int IR_DEPTH   = 32;

  // Opcodes are carried as raw bits so undefined encodings pass through untouched.
  typedef logic [3:0] opcode_t;
  localparam opcode_t OP_ZERO  = 4'd0;
  localparam opcode_t OP_PASSA = 4'd1;
  localparam opcode_t OP_PASSB = 4'd2;
  localparam opcode_t OP_ADD   = 4'd3;
  localparam opcode_t OP_SUB   = 4'd4;
  localparam opcode_t OP_MULT  = 4'd5;
  localparam opcode_t OP_DIV   = 4'd6;
  localparam opcode_t OP_MOD   = 4'd7;

  typedef logic signed [31:0]            operand_t;
  typedef logic [$clog2(IR_DEPTH)-1:0]   address_t;
  typedef logic [$clog2(IR_NUM_REQ)-1:0] req_id_t;

  typedef struct packed {
    opcode_t            opc;
    operand_t           op_a;
    operand_t           op_b;
    logic signed [63:0] result;
  } instruction_t;

  // Circular-buffer pointer advance; wraps after the last entry.
  function automatic address_t ptr_inc(input address_t p, input address_t last);
    return (p == last) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/instr_reg_scheduler_arb.sv
// Combinational round-robin arbiter: first requester at or after pri_ptr wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pri_ptr,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  int   idx;
  logic found;

  // Cyclic search starting at the priority pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(pri_ptr) + i) % N;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Front end of the instruction register: arbitrates writers into a circular
// buffer and streams stored entries, tagged with their source, to one consumer.
module instr_reg_scheduler
  import instr_reg_scheduler_pkg::*;
#(
  parameter int NUM_REQ = IR_NUM_REQ,
  parameter int DEPTH   = IR_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  opcode_t                    req_opcode    [NUM_REQ],
  input  operand_t                   req_operand_a [NUM_REQ],
  input  operand_t                   req_operand_b [NUM_REQ],
  output logic                       load_en,
  output address_t                   write_pointer,
  output opcode_t                    opcode,
  output operand_t                   operand_a,
  output operand_t                   operand_b,
  output address_t                   read_pointer,
  input  instruction_t               instruction_word,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output instruction_t               rsp_instruction,
  output logic [$clog2(NUM_REQ)-1:0] rsp_src,
  output logic [ADDR_W:0]            count,
  output logic                       full,
  output logic                       empty
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam address_t         PTR_LAST = address_t'(DEPTH - 1);
  localparam logic [IDX_W-1:0] RR_LAST  = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  address_t         wr_ptr_q, wr_ptr_d;
  address_t         rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q,  count_d;
  logic [IDX_W-1:0] src_tag_q [DEPTH];
  logic [IDX_W-1:0] src_tag_d [DEPTH];

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   sel;
  logic               arb_en;
  logic               do_write;
  logic               do_read;

  // Status and handshakes; everything is held quiet while reset is asserted.
  always_comb begin
    empty     = reset | (count_q == '0);
    full      = !reset & (count_q == CNT_FULL);
    arb_en    = !reset & (count_q != CNT_FULL);
    req_ready = grant;
    do_write  = |(req_valid & grant);
    rsp_valid = !empty;
    do_read   = rsp_valid & rsp_ready;
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .pri_ptr   (rr_ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Register write port and read-side outputs; idle data follows rr_ptr to avoid X.
  always_comb begin
    sel             = do_write ? grant_idx : rr_ptr_q;
    load_en         = do_write;
    write_pointer   = wr_ptr_q;
    opcode          = req_opcode[sel];
    operand_a       = req_operand_a[sel];
    operand_b       = req_operand_b[sel];
    read_pointer    = rd_ptr_q;
    rsp_instruction = instruction_word;
    rsp_src         = src_tag_q[rd_ptr_q];
    count           = count_q;
  end

  // Next-state for pointers, occupancy and source tags.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    src_tag_d = src_tag_q;
    if (do_write) begin
      src_tag_d[wr_ptr_q] = grant_idx;
      wr_ptr_d            = ptr_inc(wr_ptr_q, PTR_LAST);
      rr_ptr_d            = (grant_idx == RR_LAST) ? '0 : grant_idx + 1'b1;
    end
    if (do_read) begin
      rd_ptr_d = ptr_inc(rd_ptr_q, PTR_LAST);
    end
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Source tags need no reset; empty masks stale entries.
  always_ff @(posedge clk) begin
    src_tag_q <= src_tag_d;
  end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler with a behavioural instruction register.
module tb_instr_reg_scheduler;
  import instr_reg_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  opcode_t      req_opcode    [2];
  operand_t     req_operand_a [2];
  operand_t     req_operand_b [2];
  logic         load_en;
  address_t     write_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         rsp_valid;
  logic         rsp_ready;
  instruction_t rsp_instruction;
  req_id_t      rsp_src;
  logic [5:0]   count;
  logic         full;
  logic         empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_reg_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_operand_a    (req_operand_a),
    .req_operand_b    (req_operand_b),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_instruction  (rsp_instruction),
    .rsp_src          (rsp_src),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  // Behavioural instruction register: computes the result when written.
  function automatic instruction_t mk_word(input opcode_t o, input operand_t a, input operand_t b);
    longint r;
    case (o)
      OP_ADD:  r = longint'(a) + longint'(b);
      OP_SUB:  r = longint'(a) - longint'(b);
      default: r = 0;
    endcase
    return '{opc: o, op_a: a, op_b: b, result: r};
  endfunction

  instruction_t mem [32];
  always_ff @(posedge clk) begin
    if (load_en) mem[write_pointer] <= mk_word(opcode, operand_a, operand_b);
  end
  assign instruction_word = mem[read_pointer];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic rr,
                       input int a0, input int b0, input int a1, input int b1);
    req_valid        = v;
    rsp_ready        = rr;
    req_operand_a[0] = a0;
    req_operand_b[0] = b0;
    req_operand_a[1] = a1;
    req_operand_b[1] = b1;
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] v;
    logic       rr;
    int         a0, b0, a1, b1;
    logic [1:0] e_rdy;
    logic       e_ld;
    int         e_wp;
    int         e_cnt;
    logic       e_rv;
    int         e_src;
    longint     e_res;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] v, input logic rr,
                               input int a0, input int b0, input int a1, input int b1,
                               input logic [1:0] e_rdy, input logic e_ld, input int e_wp,
                               input int e_cnt, input logic e_rv, input int e_src, input longint e_res);
    return '{v, rr, a0, b0, a1, b1, e_rdy, e_ld, e_wp, e_cnt, e_rv, e_src, e_res};
  endfunction

  vec_t tbl [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle, single write/read, round-robin burst and drain.
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(2'b01, 0, 5, 3, 0, 0,    2'b01, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 1, 1, 1, 0, 8));
    tbl.push_back(mkv(2'b00, 0, 0, 0, 0, 0,    2'b00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(2'b10, 0, 0, 0, 20, 7,   2'b10, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(2'b11, 0, 1, 1, 50, 5,   2'b01, 1, 2, 1, 1, 1, 13));
    tbl.push_back(mkv(2'b11, 0, 2, 2, 50, 5,   2'b10, 1, 3, 2, 1, 1, 13));
    tbl.push_back(mkv(2'b11, 0, 2, 2, 9, 10,   2'b01, 1, 4, 3, 1, 1, 13));
    tbl.push_back(mkv(2'b11, 0, 6, 7, 9, 10,   2'b10, 1, 5, 4, 1, 1, 13));
    tbl.push_back(mkv(2'b11, 0, 6, 7, 0, 0,    2'b01, 1, 6, 5, 1, 1, 13));
    tbl.push_back(mkv(2'b11, 0, 0, 0, 0, 0,    2'b10, 1, 7, 6, 1, 1, 13));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 7, 1, 1, 13));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 6, 1, 0, 2));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 5, 1, 1, 45));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 4, 1, 0, 4));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 3, 1, 1, -1));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 2, 1, 0, 13));
    tbl.push_back(mkv(2'b00, 1, 0, 0, 0, 0,    2'b00, 0, 8, 1, 1, 1, 0));
    tbl.push_back(mkv(2'b00, 0, 0, 0, 0, 0,    2'b00, 0, 8, 0, 0, 0, 0));

    req_opcode[0] = OP_ADD;
    req_opcode[1] = OP_SUB;
    drive(2'b11, 1'b0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    // Inside the reset cycle, with both requesters asking.
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].rr, tbl[k].a0, tbl[k].b0, tbl[k].a1, tbl[k].b1);
      #3;
      chk($sformatf("v%0d_req_ready", k), req_ready, tbl[k].e_rdy);
      chk($sformatf("v%0d_load_en", k), load_en, tbl[k].e_ld);
      chk($sformatf("v%0d_write_pointer", k), write_pointer, tbl[k].e_wp);
      chk($sformatf("v%0d_count", k), count, tbl[k].e_cnt);
      chk($sformatf("v%0d_empty", k), empty, (tbl[k].e_cnt == 0) ? 1 : 0);
      chk($sformatf("v%0d_rsp_valid", k), rsp_valid, tbl[k].e_rv);
      if (tbl[k].e_ld) begin
        chk($sformatf("v%0d_operand_a", k), operand_a,
            (tbl[k].e_rdy == 2'b01) ? tbl[k].a0 : tbl[k].a1);
        chk($sformatf("v%0d_opcode", k), opcode,
            (tbl[k].e_rdy == 2'b01) ? OP_ADD : OP_SUB);
      end
      if (tbl[k].e_rv) begin
        chk($sformatf("v%0d_rsp_src", k), rsp_src, tbl[k].e_src);
        chk($sformatf("v%0d_result", k), rsp_instruction.result, tbl[k].e_res);
      end
      tick();
    end

    // Fill to full with an undefined opcode slipped in, then read one and refill.
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      req_opcode[0] = (i == 5) ? opcode_t'(4'hF) : OP_ADD;
      drive(2'b01, 1'b0, 100 + i, 0, 0, 0);
      #3;
      chk($sformatf("fill%0d_ready", i), req_ready, 2'b01);
      chk($sformatf("fill%0d_wp", i), write_pointer, i);
      if (i == 5) chk("fill_opcode_passthru", opcode, 4'hF);
      tick();
    end
    req_opcode[0] = OP_ADD;
    drive(2'b11, 1'b0, 7, 0, 0, 0);
    #3;
    chk("full_flag", full, 1);
    chk("full_count", count, 32);
    chk("full_req_ready", req_ready, 0);
    chk("full_load_en", load_en, 0);
    chk("full_rsp_src", rsp_src, 0);
    chk("full_result", rsp_instruction.result, 100);
    tick();
    #3;
    chk("full_hold_result", rsp_instruction.result, 100);
    chk("full_hold_rptr", read_pointer, 0);
    rsp_ready = 1'b1;
    #1;
    chk("full_read_req_ready", req_ready, 0);
    tick();
    drive(2'b01, 1'b0, 7, 0, 0, 0);
    #3;
    chk("after_read_full", full, 0);
    chk("after_read_count", count, 31);
    chk("after_read_ready", req_ready, 2'b01);
    chk("wrap_write_pointer", write_pointer, 0);
    chk("after_read_rptr", read_pointer, 1);
    chk("after_read_result", rsp_instruction.result, 101);
    tick();
    #3;
    chk("refill_count", count, 32);
    chk("refill_full", full, 1);
    tick();

    // Steady simultaneous read and write at count=1.
    pulse_reset();
    drive(2'b01, 1'b0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 1'b1, i + 1, 0, 0, 0);
      #3;
      chk($sformatf("rw%0d_count", i), count, 1);
      chk($sformatf("rw%0d_result", i), rsp_instruction.result, i);
      chk($sformatf("rw%0d_rptr", i), read_pointer, i);
      chk($sformatf("rw%0d_wptr", i), write_pointer, i + 1);
      tick();
    end
    drive(2'b00, 1'b0, 0, 0, 0, 0);
    #3;
    chk("rw_end_count", count, 1);
    chk("rw_end_wptr", write_pointer, 11);
    chk("rw_end_rptr", read_pointer, 10);
    tick();

    // Reset in the middle of a stream of seven entries.
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, 1'b0, i, i, i, i);
      tick();
    end
    #3;
    chk("mid_count_before", count, 7);
    reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    #3;
    chk("mid_count", count, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_empty", empty, 1);
    chk("mid_write_pointer", write_pointer, 0);
    chk("mid_rr_ptr_grant", req_ready, 2'b01);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
